serial_add_ctrl: RTL
====================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range is 2..32.
REQ-002 Port clk SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-003 Port rst SHALL be an input, 1 bit wide: asynchronous, active-high reset.
REQ-004 Port start SHALL be an input, 1 bit wide: request to begin an addition; sampled only while ready=1.
REQ-005 Port a SHALL be an input, WIDTH bits wide: operand A, captured on the accepting edge.
REQ-006 Port b SHALL be an input, WIDTH bits wide: operand B, captured on the accepting edge.
REQ-007 Port cin SHALL be an input, 1 bit wide: carry-in, captured on the accepting edge.
REQ-008 Port ready SHALL be an output, 1 bit wide: high only in state IDLE.
REQ-009 Port done SHALL be an output, 1 bit wide: one-cycle pulse marking sum/cout valid.
REQ-010 Port sum SHALL be an output, WIDTH bits wide: result bits WIDTH-1..0 of a+b+cin.
REQ-011 Port cout SHALL be an output, 1 bit wide: carry out of bit WIDTH-1.

Function
REQ-012 The block SHALL instantiate exactly one full_adder and SHALL use it as its only addition datapath, one bit per cycle, LSB first.
REQ-013 The FSM SHALL have three states, IDLE, RUN and DONE, encoded as 2 bits; the unused encoding SHALL go to IDLE.
REQ-014 In IDLE with start=1 at a rising edge, the block SHALL capture a, b and cin into shift/carry registers, clear the bit counter to 0, and go to RUN.
REQ-015 In IDLE with start=0, the block SHALL stay in IDLE with all registers unchanged.
REQ-016 Each RUN cycle, the full_adder SHALL take a_reg[0], b_reg[0] and the carry register; at the edge, its sum bit SHALL shift into sum_reg MSB (shift right), a_reg and b_reg SHALL shift right, the carry register SHALL take its carry, and the counter SHALL increment.
REQ-017 At the edge where the counter equals WIDTH-1, the FSM SHALL go to DONE; RUN therefore lasts exactly WIDTH cycles.
REQ-018 In DONE, done SHALL be 1 for exactly one cycle, then the FSM SHALL go to IDLE.
REQ-019 Latency SHALL be WIDTH+1 rising edges from the accepting edge to the edge that ends the done cycle; done first rises WIDTH edges after acceptance.
REQ-020 sum and cout SHALL be valid in the done cycle and SHALL hold until the next accepted start begins shifting.
REQ-021 Outputs sum and cout SHALL be driven from registers only.
REQ-022 While in RUN or DONE, start and operand inputs SHALL be ignored; there is no queuing.
REQ-023 If start is held high continuously, a new operation SHALL be accepted on every IDLE cycle, giving one result per WIDTH+2 cycles.
REQ-024 The counter width SHALL be ceil(log2(WIDTH)) bits; the arithmetic SHALL be exact modulo 2^(WIDTH+1) across {cout,sum}.

Reset
REQ-025 Asserting rst SHALL immediately, without waiting for a clock edge, force state IDLE and set ready=1, done=0, sum=0, cout=0, and clear the counter, carry and operand registers.
REQ-026 rst asserted mid-RUN or in DONE SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Verification (WIDTH=8)
REQ-027 The bench SHALL apply a=0xFF, b=0x01, cin=0, start for one cycle -> ready low for 9 cycles, done pulse 8 edges after acceptance, sum=0x00, cout=1.
REQ-028 The bench SHALL apply a=0x5A, b=0xA5, cin=1 -> sum=0x00, cout=1; then a=0x3C, b=0x0F, cin=0 -> sum=0x4B, cout=0.
REQ-029 The bench SHALL pulse start with a=0x11, b=0x22 during RUN of an 0x01+0x01 operation -> the result is 0x02, cout=0, with a single done and no second operation.
REQ-030 The bench SHALL assert rst asynchronously (between edges) at RUN bit 4 -> outputs are zero and ready=1 before the next edge, no done occurs, and a following 0x10+0x20 gives 0x30.
REQ-031 The bench SHALL hold start high for 30 cycles with fixed operands 0x80+0x80 -> done pulses every 10 cycles, each with sum=0x00, cout=1.
REQ-032 The bench SHALL run 1000 random a, b and cin values with random start gaps -> {cout,sum} equals a+b+cin every time.

Source files
------------

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add_ctrl (with helper full_adder)
//  Description : Bit-serial adder controller. Captures two WIDTH-bit operands
//                and a carry-in, then adds them one bit per cycle, LSB first,
//                through a single full_adder. {cout,sum} holds a+b+cin.
//  Revision    : 1.0 - initial release
// ============================================================================

// One-bit full adder: the only addition datapath of the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int                 c_cnt_w    = $clog2(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;

  logic               w_fa_sum;
  logic               w_fa_carry;

  // The single adder always looks at the current LSBs and running carry.
  full_adder u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (carry_q),
    .s  (w_fa_sum),
    .co (w_fa_carry)
  );

  // Next-state and datapath decode; everything holds unless a state acts.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        // sum and cout are left alone so the previous result stays visible
        // until the new operation starts shifting.
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d   = {w_fa_sum, sum_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = w_fa_carry;
        cnt_d   = cnt_q + c_cnt_one;
        if (cnt_q == c_last_cnt) begin
          // Carry out of the MSB is latched separately so cout changes only
          // when the full result is complete.
          cout_d  = w_fa_carry;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign cout  = cout_q;

endmodule
`default_nettype wire
